// File: rtl/wb_rr_arbiter_pkg.sv
// Shared Wishbone widths, arbiter state encoding and small sizing helpers
// for the round-robin slave-port arbiter.
package wb_rr_arbiter_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Width of an index into n masters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of the per-master request/response lines and the shared slave port.
// The slave modport is the arbiter's view; master is the view of whatever surrounds it.
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  import wb_rr_arbiter_pkg::*;

  logic [NUM_MASTERS-1:0]          m_cyc;
  logic [NUM_MASTERS-1:0]          m_stb;
  logic [NUM_MASTERS-1:0]          m_we;
  logic [NUM_MASTERS*WB_ADR_W-1:0] m_adr;
  logic [NUM_MASTERS*WB_DAT_W-1:0] m_dat_w;
  logic [NUM_MASTERS*WB_SEL_W-1:0] m_sel;
  logic [NUM_MASTERS-1:0]          m_stall;
  logic [NUM_MASTERS-1:0]          m_ack;
  logic [NUM_MASTERS-1:0]          m_err;
  logic [WB_DAT_W-1:0]             m_dat_r;

  logic                            s_cyc;
  logic                            s_stb;
  logic                            s_we;
  logic [WB_ADR_W-1:0]             s_adr;
  logic [WB_DAT_W-1:0]             s_dat_w;
  logic [WB_SEL_W-1:0]             s_sel;
  logic                            s_stall;
  logic                            s_ack;
  logic                            s_err;
  logic [WB_DAT_W-1:0]             s_dat_r;

  logic [NUM_MASTERS-1:0]          grant;

  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
    output m_stall, m_ack, m_err, m_dat_r,
    output s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
    input  s_stall, s_ack, s_err, s_dat_r,
    output grant
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
    input  m_stall, m_ack, m_err, m_dat_r,
    input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
    output s_stall, s_ack, s_err, s_dat_r,
    input  grant
  );

endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping,
// returned one-hot (all zero when nobody requests).
module wb_rr_arbiter_rr_pick
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0]          req,
  input  logic [idx_w(NUM_MASTERS)-1:0]   last,
  output logic [NUM_MASTERS-1:0]          gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!found && req[j] && (((int'(last) + k) % NUM_MASTERS) == j)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave among several masters:
// grant held for a whole cyc, outstanding tracking, response routing, hung-slave timeout.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int MAX_OUTST      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_rr_arbiter_if.slave  bus
);

  localparam int NM = NUM_MASTERS;
  localparam int LW = idx_w(NM);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic          TMO_EN    = (TIMEOUT_CYCLES > 0);

  arb_state_e    state, state_nxt;
  logic [NM-1:0] grant, grant_nxt, pick;
  logic [LW-1:0] last, last_nxt, gi;
  logic [OW-1:0] outst, outst_nxt;
  logic [TW-1:0] tmo, tmo_nxt;

  logic                own_cyc, own_stb;
  logic                s_cyc, s_stb, s_we;
  logic [WB_ADR_W-1:0] s_adr;
  logic [WB_DAT_W-1:0] s_dat_w;
  logic [WB_SEL_W-1:0] s_sel;
  logic                outst_nz, outst_full;
  logic                accept, resp, tmo_run, tmo_fire;

  wb_rr_arbiter_rr_pick #(
    .NUM_MASTERS (NM)
  ) u_pick (
    .req  (bus.m_cyc),
    .last (last),
    .gnt  (pick)
  );

  // Owner mux; grant is all-zero in IDLE so the slave side reads as quiet.
  always_comb begin
    gi      = '0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    for (int i = 0; i < NM; i++) begin
      if (grant[i]) begin
        gi      = LW'(i);
        own_cyc = bus.m_cyc[i];
        own_stb = bus.m_stb[i];
        s_we    = bus.m_we[i];
        s_adr   = bus.m_adr[i*WB_ADR_W +: WB_ADR_W];
        s_dat_w = bus.m_dat_w[i*WB_DAT_W +: WB_DAT_W];
        s_sel   = bus.m_sel[i*WB_SEL_W +: WB_SEL_W];
      end
    end
  end

  assign outst_nz   = (outst != '0);
  assign outst_full = (outst == OUTST_MAX);
  assign s_cyc      = own_cyc;
  assign s_stb      = own_cyc & own_stb & ~outst_full;
  assign accept     = s_stb & ~bus.s_stall;
  // Responses with nothing outstanding are stray (e.g. after an abort) and are swallowed.
  assign resp       = (bus.s_ack | bus.s_err) & outst_nz;
  assign tmo_run    = own_cyc & outst_nz & ~resp & ~accept;
  assign tmo_fire   = TMO_EN & tmo_run & (tmo == TMO_LAST);

  assign bus.s_cyc   = s_cyc;
  assign bus.s_stb   = s_stb;
  assign bus.s_we    = s_we;
  assign bus.s_adr   = s_adr;
  assign bus.s_dat_w = s_dat_w;
  assign bus.s_sel   = s_sel;
  assign bus.m_stall = ~grant | {NM{bus.s_stall | outst_full}};
  assign bus.m_ack   = grant & {NM{bus.s_ack & outst_nz}};
  assign bus.m_err   = grant & {NM{(bus.s_err & outst_nz) | tmo_fire}};
  assign bus.m_dat_r = bus.s_dat_r;
  assign bus.grant   = grant;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    outst_nxt = outst;
    tmo_nxt   = tmo;
    if (state == ARB_IDLE) begin
      if (|bus.m_cyc) begin
        state_nxt = ARB_BUSY;
        grant_nxt = pick;
      end
    end else if (!own_cyc) begin
      // Owner released (possibly mid-flight): anything still outstanding is abandoned.
      state_nxt = ARB_IDLE;
      grant_nxt = '0;
      last_nxt  = gi;
      outst_nxt = '0;
      tmo_nxt   = '0;
    end else begin
      if (accept && !resp)
        outst_nxt = outst + OW'(1);
      else if (!accept && (resp || tmo_fire))
        outst_nxt = outst - OW'(1);
      if (accept || resp || tmo_fire)
        tmo_nxt = '0;
      else if (tmo_run)
        tmo_nxt = tmo + TW'(1);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ARB_IDLE;
      grant <= '0;
      last  <= LW'(NM - 1);
      outst <= '0;
      tmo   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      outst <= outst_nxt;
      tmo   <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with two masters, MAX_OUTST=4, TIMEOUT_CYCLES=8.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_wb_rr_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  wb_rr_arbiter_if #(.NUM_MASTERS(2)) bus ();

  wb_rr_arbiter #(
    .NUM_MASTERS    (2),
    .MAX_OUTST      (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.m_cyc   = '0;
    bus.m_stb   = '0;
    bus.m_we    = '0;
    bus.m_adr   = {32'h0000_0200, 32'h0000_0100};
    bus.m_dat_w = {32'h2222_2222, 32'h1111_1111};
    bus.m_sel   = 8'hFF;
    bus.s_stall = 1'b0;
    bus.s_ack   = 1'b0;
    bus.s_err   = 1'b0;
    bus.s_dat_r = 32'h0;

    // Reset holds everything quiet even with requests present
    step();
    bus.m_cyc = 2'b11; bus.m_stb = 2'b11;
    #1;
    chk("rst_grant", 32'(bus.grant), 'h0);
    chk("rst_stall", 32'(bus.m_stall), 'h3);
    chk("rst_ack",   32'(bus.m_ack), 'h0);
    chk("rst_err",   32'(bus.m_err), 'h0);
    chk("rst_scyc",  32'(bus.s_cyc), 'h0);
    chk("rst_sstb",  32'(bus.s_stb), 'h0);
    step();
    #1;
    chk("rst_hold_grant", 32'(bus.grant), 'h0);
    bus.m_cyc = '0; bus.m_stb = '0; rst = 1'b0;

    // Two masters contend: order 0,1,0,1
    step();
    bus.m_cyc = 2'b11;
    #1;
    chk("t2_idle_grant", 32'(bus.grant), 'h0);
    chk("t2_idle_stall", 32'(bus.m_stall), 'h3);
    step(); #1;
    chk("t2_g0_first", 32'(bus.grant), 'h1);
    chk("t2_m1_stalled", 32'(bus.m_stall), 'h2);
    chk("t2_scyc_on", 32'(bus.s_cyc), 'h1);
    step(); #1;
    chk("t2_g0_hold2", 32'(bus.grant), 'h1);
    step(); #1;
    chk("t2_g0_hold3", 32'(bus.grant), 'h1);
    bus.m_cyc = 2'b10;
    #1;
    chk("t2_rel0_scyc", 32'(bus.s_cyc), 'h0);
    step();
    bus.m_cyc = 2'b11;
    #1;
    chk("t2_gap1", 32'(bus.grant), 'h0);
    step(); #1;
    chk("t2_g1_second", 32'(bus.grant), 'h2);
    chk("t2_m0_stalled", 32'(bus.m_stall), 'h1);
    step();
    step(); #1;
    chk("t2_g1_hold3", 32'(bus.grant), 'h2);
    bus.m_cyc = 2'b01;
    #1;
    chk("t2_rel1_scyc", 32'(bus.s_cyc), 'h0);
    step();
    bus.m_cyc = 2'b11;
    #1;
    chk("t2_gap2", 32'(bus.grant), 'h0);
    step(); #1;
    chk("t2_g0_third", 32'(bus.grant), 'h1);
    bus.m_cyc = 2'b10;
    step(); #1;
    chk("t2_gap3", 32'(bus.grant), 'h0);
    step(); #1;
    chk("t2_g1_fourth", 32'(bus.grant), 'h2);
    bus.m_cyc = 2'b00;

    // Single read by master 0 at 0x100
    step();
    bus.m_cyc = 2'b01; bus.m_stb = 2'b01;
    #1;
    chk("t1_idle_grant", 32'(bus.grant), 'h0);
    chk("t1_idle_scyc", 32'(bus.s_cyc), 'h0);
    step(); #1;
    chk("t1_grant", 32'(bus.grant), 'h1);
    chk("t1_sstb", 32'(bus.s_stb), 'h1);
    chk("t1_sadr", bus.s_adr, 'h100);
    chk("t1_swe", 32'(bus.s_we), 'h0);
    chk("t1_stall", 32'(bus.m_stall), 'h2);
    step();
    bus.m_stb = 2'b00; bus.s_ack = 1'b1; bus.s_dat_r = 32'hDEAD_BEEF;
    #1;
    chk("t1_ack_m0", 32'(bus.m_ack), 'h1);
    chk("t1_rdata", bus.m_dat_r, 'hDEAD_BEEF);
    chk("t1_no_err", 32'(bus.m_err), 'h0);
    step(); #1;
    chk("t1_stray_ack", 32'(bus.m_ack), 'h0);
    bus.s_ack = 1'b0; bus.m_cyc = 2'b00;
    #1;
    chk("t1_rel_scyc", 32'(bus.s_cyc), 'h0);

    // Burst of 6 against MAX_OUTST=4, acks 4 cycles after each accept
    step();
    bus.m_cyc = 2'b01; bus.m_stb = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      step(); #1;
      chk("t3_accept_stb", 32'(bus.s_stb), 'h1);
      chk("t3_accept_stall", 32'(bus.m_stall), 'h2);
    end
    step();
    bus.s_ack = 1'b1;
    #1;
    chk("t3_full_sstb", 32'(bus.s_stb), 'h0);
    chk("t3_full_stall", 32'(bus.m_stall), 'h3);
    chk("t3_ack1", 32'(bus.m_ack), 'h1);
    step(); #1;
    chk("t3_stb5", 32'(bus.s_stb), 'h1);
    chk("t3_stall5", 32'(bus.m_stall), 'h2);
    chk("t3_ack2", 32'(bus.m_ack), 'h1);
    step(); #1;
    chk("t3_stb6", 32'(bus.s_stb), 'h1);
    chk("t3_ack3", 32'(bus.m_ack), 'h1);
    step();
    bus.m_stb = 2'b00;
    #1;
    chk("t3_ack4", 32'(bus.m_ack), 'h1);
    chk("t3_stb_off", 32'(bus.s_stb), 'h0);
    step();
    bus.s_ack = 1'b0;
    #1;
    chk("t3_gap_noack", 32'(bus.m_ack), 'h0);
    step();
    bus.s_ack = 1'b1;
    #1;
    chk("t3_ack5", 32'(bus.m_ack), 'h1);
    step(); #1;
    chk("t3_ack6", 32'(bus.m_ack), 'h1);
    step(); #1;
    chk("t3_ack7_dropped", 32'(bus.m_ack), 'h0);
    step();
    bus.s_ack = 1'b0; bus.m_cyc = 2'b00;

    // Slave never answers: err exactly 8 cycles after the accept
    step();
    bus.m_cyc = 2'b01; bus.m_stb = 2'b01;
    step(); #1;
    chk("t4_accept", 32'(bus.s_stb), 'h1);
    step();
    bus.m_stb = 2'b00;
    #1;
    chk("t4_wait_c2", 32'(bus.m_err), 'h0);
    for (int k = 3; k <= 8; k++) begin
      step(); #1;
      chk("t4_wait", 32'(bus.m_err), 'h0);
    end
    step(); #1;
    chk("t4_timeout_err", 32'(bus.m_err), 'h1);
    chk("t4_timeout_noack", 32'(bus.m_ack), 'h0);
    step(); #1;
    chk("t4_err_pulse_end", 32'(bus.m_err), 'h0);
    bus.s_ack = 1'b1;
    #1;
    chk("t4_late_ack_dropped", 32'(bus.m_ack), 'h0);
    chk("t4_outst_zero_stall", 32'(bus.m_stall), 'h2);
    step();
    bus.s_ack = 1'b0; bus.m_cyc = 2'b00;

    // Reset mid-burst, then master 0 wins the tie
    step();
    bus.m_cyc = 2'b01; bus.m_stb = 2'b01;
    step(); #1;
    chk("t6_grant", 32'(bus.grant), 'h1);
    step();
    bus.m_cyc = 2'b11;
    #1;
    chk("t6_pre_rst_stall", 32'(bus.m_stall), 'h2);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_scyc", 32'(bus.s_cyc), 'h0);
    chk("t6_rst_grant", 32'(bus.grant), 'h0);
    chk("t6_rst_stall", 32'(bus.m_stall), 'h3);
    step(); #1;
    chk("t6_rst_hold", 32'(bus.grant), 'h0);
    rst = 1'b0;
    step(); #1;
    chk("t6_tie_m0", 32'(bus.grant), 'h1);
    chk("t6_scyc_back", 32'(bus.s_cyc), 'h1);
    bus.s_ack = 1'b1;
    #1;
    chk("t6_outst_cleared", 32'(bus.m_ack), 'h0);
    bus.s_ack = 1'b0; bus.m_cyc = 2'b00; bus.m_stb = 2'b00;

    // Owner aborts with 2 outstanding; late ack swallowed, master 1 granted 2 cycles later
    step();
    bus.m_cyc = 2'b01; bus.m_stb = 2'b01;
    step(); #1;
    chk("t5_accept1", 32'(bus.s_stb), 'h1);
    step();
    bus.m_cyc = 2'b11;
    #1;
    chk("t5_m1_waits", 32'(bus.m_stall), 'h2);
    step();
    bus.m_cyc = 2'b10; bus.m_stb = 2'b00;
    #1;
    chk("t5_drop_scyc", 32'(bus.s_cyc), 'h0);
    chk("t5_drop_grant", 32'(bus.grant), 'h1);
    step();
    bus.s_ack = 1'b1;
    #1;
    chk("t5_late_ack", 32'(bus.m_ack), 'h0);
    chk("t5_idle_grant", 32'(bus.grant), 'h0);
    step(); #1;
    chk("t5_m1_granted", 32'(bus.grant), 'h2);
    chk("t5_m1_scyc", 32'(bus.s_cyc), 'h1);
    chk("t5_late_ack2", 32'(bus.m_ack), 'h0);
    bus.s_ack = 1'b0; bus.m_cyc = 2'b00;
    step(); #1;
    chk("t5_end_idle", 32'(bus.grant), 'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
